data_memory_lsu: RTL and testbench

Byte-addressed RV32I data memory with integrated load/store unit: accepts one request at a time over a valid/ready handshake and performs width selection, byte-lane enables, write-data replication, load alignment and sign/zero extension. Optional misalignment/illegal-op fault detection. Programmable wait states. Sits between the core's MEM stage and on-chip storage, replacing the bare byte-lane RAM that needed pre-formatted lane enables from the core.

---
 rtl/data_memory_lsu_if.sv | 33 +++
 rtl/data_memory_lsu.sv | 188 ++++++++++++++++++
 tb/tb_data_memory_lsu.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/data_memory_lsu_if.sv
// data_memory_lsu_if: request/response bundle between the core MEM stage
// (master) and the data memory load/store unit (slave).
//   req_valid/req_ready : request handshake, transfer when both high
//   req_we              : 1 = store, 0 = load
//   req_funct3          : RV32I access width/sign code
//   req_addr            : byte address
//   req_wdata           : LSB-aligned store data
//   rsp_valid           : one-cycle response pulse
//   rsp_rdata           : formatted load data (0 for stores/faults)
//   rsp_fault           : access rejected, qualified by rsp_valid
interface data_memory_lsu_if #(
  parameter int ADDR_WIDTH = 14
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [31:0]           req_wdata;
  logic                  rsp_valid;
  logic [31:0]           rsp_rdata;
  logic                  rsp_fault;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_fault
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_fault
  );
endinterface

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: byte-addressed RV32I data memory with integrated
// load/store unit. One request at a time over a valid/ready handshake;
// does lane enables, store-data replication, load alignment and sign/zero
// extension. WAIT_STATES (0..15) extra cycles precede the RAM access.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : data_memory_lsu_if.slave (request + response signals)
// Optional feature: define DATA_MEMORY_LSU_FAULT_EN to flag misaligned
// accesses and illegal funct3 codes via rsp_fault. Without it, offsets are
// forced aligned, illegal load codes act as LW and store funct3[2] is ignored.
module data_memory_lsu #(
  parameter int ADDR_WIDTH  = 14,
  parameter int WAIT_STATES = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  data_memory_lsu_if.slave bus
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  localparam state_t     FIRST_STATE = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
  localparam logic [3:0] WAIT_LAST   = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t state_q, state_d;
  logic [3:0] wait_cnt;

  logic                  r_we;
  logic [2:0]            r_f3;
  logic [ADDR_WIDTH-3:0] r_idx;
  logic [1:0]            r_off;
  logic [31:0]           r_wdata;

  logic        rsp_valid_q;
  logic        rsp_fault_q;
  logic [31:0] rsp_rdata_q;

  logic        req_ready;
  logic        xfer;

  size_t       size;
  logic        uns;
  logic        fault;
  logic [1:0]  eff_off;
  logic [3:0]  lanes;
  logic [31:0] wdata_rep;
  logic        mem_we;
  logic [31:0] rd_word;
  logic [31:0] rd_shift;
  logic [31:0] load_data;

  logic [7:0] mem [4][DEPTH];

  assign req_ready = rst_n && (state_q == S_IDLE || state_q == S_RESP);
  assign xfer      = bus.req_valid && req_ready;

  // State register, wait counter, request latch and registered response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      wait_cnt    <= '0;
      r_we        <= 1'b0;
      r_f3        <= '0;
      r_idx       <= '0;
      r_off       <= '0;
      r_wdata     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_fault_q <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q  <= state_d;
      wait_cnt <= (state_q == S_WAIT) ? wait_cnt + 4'd1 : '0;
      if (xfer) begin
        r_we    <= bus.req_we;
        r_f3    <= bus.req_funct3;
        r_idx   <= bus.req_addr[ADDR_WIDTH-1:2];
        r_off   <= bus.req_addr[1:0];
        r_wdata <= bus.req_wdata;
      end
      rsp_valid_q <= (state_q == S_ACCESS);
      if (state_q == S_ACCESS) begin
        rsp_fault_q <= fault;
        rsp_rdata_q <= (r_we || fault) ? '0 : load_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_RESP: state_d = xfer ? FIRST_STATE : S_IDLE;
      S_WAIT:         if (wait_cnt == WAIT_LAST) state_d = S_ACCESS;
      S_ACCESS:       state_d = S_RESP;
      default:        state_d = S_IDLE;
    endcase
  end

  // Access decode from the latched request.
  always_comb begin
    size    = SZ_W;
    uns     = 1'b0;
    fault   = 1'b0;
    eff_off = r_off;
    if (r_we) begin
      case (r_f3[1:0])
        2'b00:   size = SZ_B;
        2'b01:   size = SZ_H;
        default: size = SZ_W;
      endcase
`ifdef DATA_MEMORY_LSU_FAULT_EN
      if (r_f3[2]) fault = 1'b1;
`endif
    end else begin
      case (r_f3)
        3'b000: size = SZ_B;
        3'b001: size = SZ_H;
        3'b010: size = SZ_W;
        3'b100: begin size = SZ_B; uns = 1'b1; end
        3'b101: begin size = SZ_H; uns = 1'b1; end
        default: begin
          size = SZ_W;
`ifdef DATA_MEMORY_LSU_FAULT_EN
          fault = 1'b1;
`endif
        end
      endcase
    end
`ifdef DATA_MEMORY_LSU_FAULT_EN
    if (size == SZ_H && r_off[0])    fault = 1'b1;
    if (size == SZ_W && r_off != '0) fault = 1'b1;
`else
    if (size == SZ_H) eff_off = {r_off[1], 1'b0};
    if (size == SZ_W) eff_off = '0;
`endif
  end

  always_comb begin
    lanes     = 4'b1111;
    wdata_rep = r_wdata;
    case (size)
      SZ_B: begin
        lanes     = 4'b0001 << eff_off;
        wdata_rep = {4{r_wdata[7:0]}};
      end
      SZ_H: begin
        lanes     = 4'b0011 << eff_off;
        wdata_rep = {2{r_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // rst_n in the enable keeps a store whose ACCESS-closing edge lands in
  // reset from reaching the banks, which have no reset of their own.
  assign mem_we = rst_n && (state_q == S_ACCESS) && r_we && !fault;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (lanes[i]) mem[i][r_idx] <= wdata_rep[8*i +: 8];
      end
    end
  end

  // The word is formatted combinationally and captured into rsp_rdata_q at
  // the ACCESS-closing edge, which is the registered read point.
  assign rd_word  = {mem[3][r_idx], mem[2][r_idx], mem[1][r_idx], mem[0][r_idx]};
  assign rd_shift = rd_word >> {eff_off, 3'b000};

  always_comb begin
    load_data = rd_shift;
    case (size)
      SZ_B: load_data = uns ? {24'h0, rd_shift[7:0]}
                            : {{24{rd_shift[7]}}, rd_shift[7:0]};
      SZ_H: load_data = uns ? {16'h0, rd_shift[15:0]}
                            : {{16{rd_shift[15]}}, rd_shift[15:0]};
      default: ;
    endcase
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_fault = rsp_fault_q;
  assign bus.rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_memory_lsu.sv
module tb_data_memory_lsu;
`ifdef DATA_MEMORY_LSU_FAULT_EN
  localparam bit FEN = 1'b1;
`else
  localparam bit FEN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n0, rst_n3;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  data_memory_lsu_if #(.ADDR_WIDTH(14)) bus0 ();
  data_memory_lsu_if #(.ADDR_WIDTH(14)) bus3 ();

  data_memory_lsu #(.ADDR_WIDTH(14), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst_n(rst_n0), .bus(bus0)
  );
  data_memory_lsu #(.ADDR_WIDTH(14), .WAIT_STATES(3)) dut3 (
    .clk(clk), .rst_n(rst_n3), .bus(bus3)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
    int          due;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per response; flag late/missing/unexpected.
  always @(negedge clk) begin
    exp_t e;
    if (bus0.rsp_valid) begin
      if (q0.size() == 0) check("d0_unexpected_rsp", bus0.rsp_valid, 1'b0);
      else begin
        e = q0.pop_front();
        check("d0_rdata", bus0.rsp_rdata, e.rdata);
        check("d0_fault", bus0.rsp_fault, e.fault);
        check("d0_rsp_cycle", cyc, e.due);
      end
    end else if (q0.size() > 0 && q0[0].due < cyc) begin
      check("d0_missing_rsp", bus0.rsp_valid, 1'b1);
      void'(q0.pop_front());
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (bus3.rsp_valid) begin
      if (q3.size() == 0) check("d3_unexpected_rsp", bus3.rsp_valid, 1'b0);
      else begin
        e = q3.pop_front();
        check("d3_rdata", bus3.rsp_rdata, e.rdata);
        check("d3_fault", bus3.rsp_fault, e.fault);
        check("d3_rsp_cycle", cyc, e.due);
      end
    end else if (q3.size() > 0 && q3[0].due < cyc) begin
      check("d3_missing_rsp", bus3.rsp_valid, 1'b1);
      void'(q3.pop_front());
    end
  end

  task automatic issue(input int d, input logic we, input logic [2:0] f3,
                       input logic [13:0] addr, input logic [31:0] wd,
                       input logic push, input logic [31:0] er, input logic ef,
                       output int waited);
    int   n;
    exp_t e;
    @(negedge clk);
    if (d == 0) begin
      bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
      bus0.req_addr = addr; bus0.req_wdata = wd;
    end else begin
      bus3.req_valid = 1'b1; bus3.req_we = we; bus3.req_funct3 = f3;
      bus3.req_addr = addr; bus3.req_wdata = wd;
    end
    n = 0;
    while (((d == 0) ? bus0.req_ready : bus3.req_ready) == 1'b0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) begin
      check((d == 0) ? "d0_ready_timeout" : "d3_ready_timeout",
            (d == 0) ? bus0.req_ready : bus3.req_ready, 1'b1);
    end else if (push) begin
      e.rdata = er;
      e.fault = ef;
      e.due   = cyc + 2 + ((d == 0) ? 0 : 3);
      if (d == 0) q0.push_back(e);
      else        q3.push_back(e);
    end
    waited = n;
    @(posedge clk);
    #1;
    if (d == 0) bus0.req_valid = 1'b0;
    else        bus3.req_valid = 1'b0;
  endtask

  task automatic do_store(input int d, input logic [2:0] f3, input logic [13:0] a,
                          input logic [31:0] wd, input logic ef);
    int w;
    issue(d, 1'b1, f3, a, wd, 1'b1, 32'h0, ef, w);
  endtask

  task automatic do_load(input int d, input logic [2:0] f3, input logic [13:0] a,
                         input logic [31:0] er, input logic ef);
    int w;
    issue(d, 1'b0, f3, a, 32'h0, 1'b1, er, ef, w);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    int w;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = '0;
    bus0.req_addr = '0; bus0.req_wdata = '0;
    bus3.req_valid = 1'b0; bus3.req_we = 1'b0; bus3.req_funct3 = '0;
    bus3.req_addr = '0; bus3.req_wdata = '0;
    rst_n0 = 1'b0;
    rst_n3 = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rsp_valid", bus0.rsp_valid, 1'b0);
    check("rst_rsp_fault", bus0.rsp_fault, 1'b0);
    check("rst_rsp_rdata", bus0.rsp_rdata, 32'h0);
    check("rst_ready_d0", bus0.req_ready, 1'b0);
    check("rst_ready_d3", bus3.req_ready, 1'b0);
    rst_n0 = 1'b1;
    rst_n3 = 1'b1;
    @(negedge clk);
    check("idle_ready_d0", bus0.req_ready, 1'b1);

    // WAIT_STATES=0 directed vectors
    do_store(0, 3'b010, 14'h10, 32'h8000_00F0, 1'b0);
    do_load (0, 3'b010, 14'h10, 32'h8000_00F0, 1'b0);
    do_store(0, 3'b010, 14'h20, 32'h1122_3344, 1'b0);
    do_store(0, 3'b000, 14'h21, 32'hFFFF_FFAB, 1'b0);
    do_load (0, 3'b000, 14'h21, 32'hFFFF_FFAB, 1'b0);
    do_load (0, 3'b100, 14'h21, 32'h0000_00AB, 1'b0);
    do_load (0, 3'b010, 14'h20, 32'h1122_AB44, 1'b0);
    do_store(0, 3'b001, 14'h32, 32'hFFFF_1234, 1'b0);
    do_load (0, 3'b001, 14'h32, 32'h0000_1234, 1'b0);
    do_store(0, 3'b001, 14'h30, 32'h0000_8001, 1'b0);
    do_load (0, 3'b101, 14'h30, 32'h0000_8001, 1'b0);
    issue(0, 1'b0, 3'b001, 14'h30, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0, w);
    check("d0_b2b_stall", w, 1);
    do_load (0, 3'b010, 14'h30, 32'h1234_8001, 1'b0);

    // Misaligned / illegal accesses
    do_store(0, 3'b010, 14'h40, 32'hCAFE_F00D, 1'b0);
    do_store(0, 3'b010, 14'h44, 32'h0000_0000, 1'b0);
    do_load (0, 3'b010, 14'h13, FEN ? 32'h0 : 32'h8000_00F0, FEN);
    do_load (0, 3'b001, 14'h31, FEN ? 32'h0 : 32'hFFFF_8001, FEN);
    do_load (0, 3'b011, 14'h10, FEN ? 32'h0 : 32'h8000_00F0, FEN);
    do_store(0, 3'b001, 14'h41, 32'h0000_5566, FEN);
    do_load (0, 3'b010, 14'h40, FEN ? 32'hCAFE_F00D : 32'hCAFE_5566, 1'b0);
    do_store(0, 3'b100, 14'h45, 32'h0000_00A5, FEN);
    do_load (0, 3'b010, 14'h44, FEN ? 32'h0 : 32'h0000_A500, 1'b0);

    // WAIT_STATES=3 back-to-back
    do_store(3, 3'b010, 14'h50, 32'h1122_3344, 1'b0);
    issue(3, 1'b0, 3'b010, 14'h50, 32'h0, 1'b1, 32'h1122_3344, 1'b0, w);
    check("d3_b2b_stall_a", w, 4);
    issue(3, 1'b0, 3'b000, 14'h53, 32'h0, 1'b1, 32'h0000_0011, 1'b0, w);
    check("d3_b2b_stall_b", w, 4);
    issue(3, 1'b0, 3'b001, 14'h52, 32'h0, 1'b1, 32'h0000_1122, 1'b0, w);
    check("d3_b2b_stall_c", w, 4);

    // Reset during WAIT of a store: no response, store dropped
    issue(3, 1'b1, 3'b010, 14'h50, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, w);
    @(negedge clk);
    rst_n3 = 1'b0;
    #1;
    check("d3_rst_ready", bus3.req_ready, 1'b0);
    check("d3_rst_valid", bus3.rsp_valid, 1'b0);
    repeat (2) @(negedge clk);
    rst_n3 = 1'b1;
    @(negedge clk);
    check("d3_post_rst_ready", bus3.req_ready, 1'b1);
    do_load(3, 3'b010, 14'h50, 32'h1122_3344, 1'b0);

    repeat (10) @(negedge clk);
    check("q0_drained", q0.size(), 0);
    check("q3_drained", q3.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
